data_sram_responder: RTL and testbench

Responder end of the data-side SRAM-like request interface driven by the Execute stage (en / we[3:0] / addr / wdata). Decodes each request to one of three targets:
- on-chip byte-writable data RAM,
- a small MMIO register window (64-bit free-running timer, LED register, scratch register),
- an error sink.
Fixed one-cycle read latency, so the pipeline needs no backpressure. Read data is consumed by the Memory stage the cycle after issue.

---
 rtl/data_sram_responder.sv | 74 +++++++
 tb/tb_data_sram_responder.sv | 110 +++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// data_sram_responder: data-side SRAM responder (en/we/addr/wdata in; rdata/rvalid/bus_err 1-cycle later) over byte-writable RAM, MMIO timer/led/scratch and an error sink; led and timer exported
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        bus_err,
  output logic [15:0] led,
  output logic [63:0] timer
);
  typedef enum logic [1:0] {T_NONE, T_RAM, T_MMIO} tgt_t;
  localparam logic [31:0] RAM_MASK  = ~((32'd1 << (RAM_AW + 2)) - 32'd1);
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_FF00;
  logic              wr, rd, ram_hit, mmio_hit;
  logic [RAM_AW-1:0] idx;
  logic [5:0]        off;
  logic [31:0]       mem [0:(1<<RAM_AW)-1];
  logic [31:0]       ram_q, mmio_q, mmio_rd, scratch, hi_shadow;
  tgt_t              tag;
  assign wr       = |data_sram_we;
  assign rd       = data_sram_en && !wr;
  assign ram_hit  = (data_sram_addr & RAM_MASK) == (RAM_BASE & RAM_MASK);
  assign mmio_hit = !ram_hit && (data_sram_addr & MMIO_MASK) == (MMIO_BASE & MMIO_MASK);
  assign idx      = data_sram_addr[RAM_AW+1:2];
  assign off      = data_sram_addr[7:2];
  always_ff @(posedge clk) begin
    if (rstn && data_sram_en && ram_hit) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_we[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      if (!wr) ram_q <= mem[idx];
    end
  end
  always_comb
    mmio_rd = off == 6'd0 ? timer[31:0] :
              off == 6'd1 ? hi_shadow :
              off == 6'd2 ? {16'b0, led} :
              off == 6'd3 ? scratch : 32'b0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_sram_rvalid <= 1'b0;
      bus_err          <= 1'b0;
      led              <= '0;
      timer            <= '0;
      scratch          <= '0;
      hi_shadow        <= '0;
      mmio_q           <= '0;
      tag              <= T_NONE;
    end else begin
      data_sram_rvalid <= rd;
      bus_err          <= data_sram_en && !ram_hit && !mmio_hit;
      timer            <= (data_sram_en && wr && mmio_hit && off <= 6'd1) ? 64'd0 : timer + 64'd1;
      if (rd) tag <= ram_hit ? T_RAM : mmio_hit ? T_MMIO : T_NONE;
      if (data_sram_en && mmio_hit) begin
        if (!wr) mmio_q <= mmio_rd;
        if (!wr && off == 6'd0) hi_shadow <= timer[63:32];
        if (off == 6'd2)
          for (int i = 0; i < 2; i++)
            if (data_sram_we[i]) led[8*i +: 8] <= data_sram_wdata[8*i +: 8];
        if (off == 6'd3)
          for (int i = 0; i < 4; i++)
            if (data_sram_we[i]) scratch[8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end
  assign data_sram_rdata = tag == T_RAM ? ram_q : tag == T_MMIO ? mmio_q : 32'b0;
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed self-checking bench for data_sram_responder
module tb_data_sram_responder;
  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [3:0]  we = 4'b0;
  logic [31:0] addr = '0, wd = '0;
  logic [31:0] rdata;
  logic        rvalid, bus_err;
  logic [15:0] led;
  logic [63:0] timer;
  int n_chk = 0, n_fail = 0;
  data_sram_responder dut (
    .clk(clk), .rstn(rstn),
    .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr), .data_sram_wdata(wd),
    .data_sram_rdata(rdata), .data_sram_rvalid(rvalid), .bus_err(bus_err),
    .led(led), .timer(timer)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = 1'b1; we = w; addr = a; wd = d;
    @(negedge clk);
    en = 1'b0; we = 4'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req(4'b0, a, 32'b0);
    check({tag, ".rdata"}, rdata, exp);
    check({tag, ".rvalid"}, rvalid, 1);
    check({tag, ".bus_err"}, bus_err, 0);
  endtask
  task automatic wr(input string tag, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    req(w, a, d);
    check({tag, ".rvalid"}, rvalid, 0);
    check({tag, ".bus_err"}, bus_err, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst.rdata", rdata, 0);
    check("rst.rvalid", rvalid, 0);
    check("rst.bus_err", bus_err, 0);
    check("rst.led", led, 0);
    check("rst.timer", timer, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    rd("tmr_lo", 32'hBFAF_0000, 32'd10);
    rd("tmr_hi", 32'hBFAF_0004, 32'd0);
    force dut.timer = 64'h0000_0001_FFFF_FFF0;
    rd("snap_lo", 32'hBFAF_0000, 32'hFFFF_FFF0);
    force dut.timer = 64'h0000_0002_0000_0005;
    @(negedge clk);
    check("live_timer", timer, 64'h0000_0002_0000_0005);
    rd("snap_hi", 32'hBFAF_0004, 32'd1);
    release dut.timer;
    wr("tmr_clr", 4'b0001, 32'hBFAF_0004, 32'b0);
    check("tmr_clr0", timer, 0);
    @(negedge clk);
    check("tmr_clr1", timer, 1);
    wr("w_full", 4'hF, 32'h100, 32'hDEAD_BEEF);
    rd("r_full", 32'h100, 32'hDEAD_BEEF);
    wr("w_b0", 4'b0001, 32'h100, 32'h0000_0011);
    rd("r_b0", 32'h100, 32'hDEAD_BE11);
    wr("w_hi", 4'b1100, 32'h100, 32'h5555_AAAA);
    rd("r_hi", 32'h100, 32'h5555_BE11);
    wr("w_raw", 4'hF, 32'h300, 32'hCAFE_F00D);
    rd("r_raw", 32'h300, 32'hCAFE_F00D);
    rd("b2b0", 32'h100, 32'h5555_BE11);
    rd("b2b1", 32'h300, 32'hCAFE_F00D);
    @(negedge clk);
    check("idle.rvalid", rvalid, 0);
    check("idle.hold", rdata, 32'hCAFE_F00D);
    wr("led_w", 4'hF, 32'hBFAF_0008, 32'h1234_ABCD);
    check("led_full", led, 16'hABCD);
    rd("led_r", 32'hBFAF_0008, 32'h0000_ABCD);
    wr("led_w1", 4'b0010, 32'hBFAF_0008, 32'h0000_FF00);
    check("led_lane1", led, 16'hFFCD);
    wr("led_w32", 4'b1100, 32'hBFAF_0008, 32'hFFFF_0000);
    check("led_ign", led, 16'hFFCD);
    wr("scr_w", 4'b0101, 32'hBFAF_000C, 32'h1122_3344);
    rd("scr_r", 32'hBFAF_000C, 32'h0022_0044);
    wr("gap_w", 4'hF, 32'hBFAF_0010, 32'hFFFF_FFFF);
    rd("gap_r", 32'hBFAF_0010, 32'h0);
    req(4'b0, 32'h8000_0000, 32'b0);
    check("un_r.rdata", rdata, 0);
    check("un_r.rvalid", rvalid, 1);
    check("un_r.bus_err", bus_err, 1);
    req(4'hF, 32'h8000_0000, 32'h1);
    check("un_w.rvalid", rvalid, 0);
    check("un_w.bus_err", bus_err, 1);
    @(negedge clk);
    check("un_idle.rvalid", rvalid, 0);
    check("un_idle.bus_err", bus_err, 0);
    wr("pre_w", 4'hF, 32'h200, 32'h5A5A_0F0F);
    rstn = 1'b0;
    en = 1'b1; we = 4'hF; addr = 32'h200; wd = 32'h1;
    @(negedge clk);
    en = 1'b0; we = 4'b0;
    check("rst_req.rvalid", rvalid, 0);
    check("rst_req.bus_err", bus_err, 0);
    check("rst_req.led", led, 0);
    rstn = 1'b1;
    rd("rst_keep", 32'h200, 32'h5A5A_0F0F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
